// File: rtl/itcm_arbiter.sv
// itcm_arbiter: shares the single-port instruction TCM between the fetch
// stage (read-only, fixed priority) and the loader/debug port (read/write).
// A starvation counter forces a loader grant after MAX_STALL consecutive
// losses. Read data is routed back to whichever requester issued the read.
module itcm_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_STALL  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [31:0]           if_req_addr,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    input  logic                  ld_req_valid,
    output logic                  ld_req_ready,
    input  logic                  ld_req_we,
    input  logic [31:0]           ld_req_addr,
    input  logic [DATA_WIDTH-1:0] ld_req_wdata,
    output logic                  ld_rsp_valid,
    output logic [DATA_WIDTH-1:0] ld_rsp_data,
    output logic                  tcm_we,
    output logic [ADDR_WIDTH-1:0] tcm_addr,
    output logic [DATA_WIDTH-1:0] tcm_wdata,
    input  logic [DATA_WIDTH-1:0] tcm_rdata
);

    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] MAX_CNT = SW'(MAX_STALL);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LD   = 2'd2;

    logic [SW-1:0]         stall_cnt_q, stall_cnt_d;
    logic [1:0]            owner_q, owner_d;
    logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
    logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
    logic                  grant_if, grant_ld;
    logic [ADDR_WIDTH-1:0] if_word, ld_word;

    // Byte address to word address; low bits and high bits alias away.
    assign if_word = if_req_addr[ADDR_WIDTH+1:2];
    assign ld_word = ld_req_addr[ADDR_WIDTH+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_req_addr[31:ADDR_WIDTH+2], if_req_addr[1:0],
                                ld_req_addr[31:ADDR_WIDTH+2], ld_req_addr[1:0]};

    // Fixed fetch priority, except when the loader has lost MAX_STALL times in a row.
    always_comb begin
        grant_if = 1'b0;
        grant_ld = 1'b0;
        if (if_req_valid && ld_req_valid) begin
            if (stall_cnt_q == MAX_CNT) grant_ld = 1'b1;
            else                        grant_if = 1'b1;
        end else if (if_req_valid) begin
            grant_if = 1'b1;
        end else if (ld_req_valid) begin
            grant_ld = 1'b1;
        end
    end

    // Drive the TCM port and the ready handshakes from the granted request.
    always_comb begin
        tcm_we    = 1'b0;
        tcm_addr  = '0;
        tcm_wdata = '0;
        if (grant_if) begin
            tcm_addr = if_word;
        end else if (grant_ld) begin
            tcm_addr = ld_word;
            if (ld_req_we) begin
                tcm_we    = rst_n;
                tcm_wdata = ld_req_wdata;
            end
        end
        if_req_ready = grant_if && rst_n;
        ld_req_ready = grant_ld && rst_n;
    end

    // Starvation counter, read-owner tag and response data routing.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ld_req_valid || grant_ld) stall_cnt_d = '0;
        else if (grant_if)             stall_cnt_d = stall_cnt_q + SW'(1);

        owner_d = OWN_NONE;
        if (if_req_ready)                   owner_d = OWN_IF;
        else if (ld_req_ready && !ld_req_we) owner_d = OWN_LD;

        // Responses are suppressed while reset is held so a read accepted
        // just before reset never surfaces.
        if_rsp_valid = rst_n && (owner_q == OWN_IF);
        ld_rsp_valid = rst_n && (owner_q == OWN_LD);
        if_rsp_data  = if_rsp_valid ? tcm_rdata : if_data_q;
        ld_rsp_data  = ld_rsp_valid ? tcm_rdata : ld_data_q;
        if_data_d    = if_rsp_data;
        ld_data_d    = ld_rsp_data;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            owner_q     <= OWN_NONE;
            if_data_q   <= '0;
            ld_data_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            owner_q     <= owner_d;
            if_data_q   <= if_data_d;
            ld_data_q   <= ld_data_d;
        end
    end

endmodule

// File: tb/tb_itcm_arbiter.sv
// tb_itcm_arbiter: directed scenarios plus randomized traffic, checked each
// cycle against a transaction-level model of the arbiter and a TCM model.
module tb_itcm_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int MS = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0]   if_req_addr;
    logic [DW-1:0] if_rsp_data;
    logic          ld_req_valid, ld_req_ready, ld_req_we, ld_rsp_valid;
    logic [31:0]   ld_req_addr;
    logic [DW-1:0] ld_req_wdata, ld_rsp_data;
    logic          tcm_we;
    logic [AW-1:0] tcm_addr;
    logic [DW-1:0] tcm_wdata, tcm_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    itcm_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_STALL(MS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_we(ld_req_we),
        .ld_req_addr(ld_req_addr), .ld_req_wdata(ld_req_wdata),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
        .tcm_we(tcm_we), .tcm_addr(tcm_addr), .tcm_wdata(tcm_wdata), .tcm_rdata(tcm_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'h1111_AAAA;
        if (i == 1) return 32'h2222_BBBB;
        if (i == 2) return 32'h3333_CCCC;
        return 32'hA5A5_0000 ^ (i * 32'h9E37_79B1);
    endfunction

    function automatic int unsigned wrd(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // TCM macro: single port, write-first, one-cycle registered read.
    logic [DW-1:0] tcm_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) tcm_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (tcm_we) tcm_mem[tcm_addr] <= tcm_wdata;
            tcm_rdata <= tcm_we ? tcm_wdata : tcm_mem[tcm_addr];
        end
    end

    // Reference model: who wins this cycle, what each accepted read returns.
    logic [31:0] ref_mem [DEPTH];
    int          losses;        // consecutive cycles the loader was refused
    int          pend;          // 0 none, 1 fetch read, 2 loader read
    logic [31:0] pend_data, last_if, last_ld;

    function automatic int m_grant();
        if (if_req_valid && ld_req_valid) return (losses >= MS) ? 2 : 1;
        if (if_req_valid) return 1;
        if (ld_req_valid) return 2;
        return 0;
    endfunction

    initial begin
        losses = 0; pend = 0; pend_data = 0; last_if = 0; last_ld = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                losses = 0; pend = 0; pend_data = 0; last_if = 0; last_ld = 0;
            end else begin
                int g;
                if (pend == 1) last_if = pend_data;
                if (pend == 2) last_ld = pend_data;
                g = m_grant();
                pend = 0;
                if (g == 1) begin
                    pend = 1; pend_data = ref_mem[wrd(if_req_addr)];
                end else if (g == 2) begin
                    if (ld_req_we) ref_mem[wrd(ld_req_addr)] = ld_req_wdata;
                    else begin pend = 2; pend_data = ref_mem[wrd(ld_req_addr)]; end
                end
                if (!ld_req_valid || g == 2) losses = 0;
                else losses++;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int g;
            logic ev_if, ev_ld;
            g = m_grant();
            if (rst_n) begin
                chk("if_req_ready", 32'(if_req_ready), 32'(g == 1));
                chk("ld_req_ready", 32'(ld_req_ready), 32'(g == 2));
                chk("tcm_we", 32'(tcm_we), 32'(g == 2 && ld_req_we));
                chk("tcm_addr", 32'(tcm_addr),
                    g == 1 ? wrd(if_req_addr) : g == 2 ? wrd(ld_req_addr) : 0);
                chk("tcm_wdata", tcm_wdata, (g == 2 && ld_req_we) ? ld_req_wdata : 32'h0);
            end else begin
                chk("rst_if_ready", 32'(if_req_ready), 0);
                chk("rst_ld_ready", 32'(ld_req_ready), 0);
                chk("rst_tcm_we", 32'(tcm_we), 0);
            end
            ev_if = rst_n && pend == 1;
            ev_ld = rst_n && pend == 2;
            chk("if_rsp_valid", 32'(if_rsp_valid), 32'(ev_if));
            chk("ld_rsp_valid", 32'(ld_rsp_valid), 32'(ev_ld));
            chk("if_rsp_data", if_rsp_data, ev_if ? pend_data : last_if);
            chk("ld_rsp_data", ld_rsp_data, ev_ld ? pend_data : last_ld);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req_valid = 0; if_req_addr = 0;
        ld_req_valid = 0; ld_req_we = 0; ld_req_addr = 0; ld_req_wdata = 0;
    endtask

    logic [9:0] pat;
    bit         acc_if, acc_ld;

    initial begin
        rst_n = 0;
        idle();
        tick(); tick();
        chk_en = 1;
        @(negedge clk);
        chk("reset if_rsp_data", if_rsp_data, 0);
        chk("reset ld_rsp_data", ld_rsp_data, 0);
        tick();
        rst_n = 1;

        // Fetch stream 0x0, 0x4, 0x8 -> A, B, C one cycle later each.
        if_req_valid = 1; if_req_addr = 32'h0;
        @(negedge clk); chk("fetch0 ready", 32'(if_req_ready), 1);
        tick(); if_req_addr = 32'h4;
        @(negedge clk); chk("fetch rsp A", if_rsp_data, 32'h1111_AAAA);
        tick(); if_req_addr = 32'h8;
        @(negedge clk); chk("fetch rsp B", if_rsp_data, 32'h2222_BBBB);
        tick(); idle();
        @(negedge clk);
        chk("fetch rsp C", if_rsp_data, 32'h3333_CCCC);
        chk("fetch rsp C valid", 32'(if_rsp_valid), 1);
        tick();

        // Loader write 0xDEADBEEF to 0x40, then read it back.
        ld_req_valid = 1; ld_req_we = 1; ld_req_addr = 32'h40; ld_req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ld write we", 32'(tcm_we), 1);
        chk("ld write addr", 32'(tcm_addr), 32'h10);
        tick(); ld_req_we = 0; ld_req_wdata = 0;
        @(negedge clk);
        chk("no rsp for write", 32'(ld_rsp_valid), 0);
        chk("read no we", 32'(tcm_we), 0);
        tick(); idle();
        @(negedge clk);
        chk("ld read valid", 32'(ld_rsp_valid), 1);
        chk("ld read data", ld_rsp_data, 32'hDEAD_BEEF);
        tick();

        // Continuous contention: loader wins every fifth cycle.
        if_req_valid = 1; if_req_addr = 32'h100;
        ld_req_valid = 1; ld_req_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); pat[i] = ld_req_ready;
            tick();
        end
        chk("contention pattern", 32'(pat), 32'h210);
        idle(); tick();

        // Loader drops after two losses; counter restarts.
        if_req_valid = 1; if_req_addr = 32'h104;
        ld_req_valid = 1; ld_req_addr = 32'h204;
        pat = 0;
        for (int i = 0; i < 8; i++) begin
            ld_req_valid = (i != 2);
            @(negedge clk); pat[i] = ld_req_ready;
            tick();
        end
        chk("restart pattern", 32'(pat), 32'h80);
        idle(); tick();

        // Aliasing: 0x1003 maps to word 0.
        ld_req_valid = 1; ld_req_we = 1; ld_req_addr = 32'h1003; ld_req_wdata = 32'hCAFE_F00D;
        @(negedge clk); chk("alias addr", 32'(tcm_addr), 0);
        tick(); idle(); if_req_valid = 1; if_req_addr = 32'h0;
        tick(); idle();
        @(negedge clk); chk("alias fetch data", if_rsp_data, 32'hCAFE_F00D);
        tick();

        // Reset the cycle after an accepted fetch.
        if_req_valid = 1; if_req_addr = 32'h8;
        @(negedge clk); chk("pre-reset ready", 32'(if_req_ready), 1);
        tick(); idle(); rst_n = 0;
        @(negedge clk); chk("dropped rsp", 32'(if_rsp_valid), 0);
        tick(); rst_n = 1;
        @(negedge clk);
        chk("post-reset if valid", 32'(if_rsp_valid), 0);
        chk("post-reset if data", if_rsp_data, 0);
        chk("post-reset ld data", ld_rsp_data, 0);
        if_req_valid = 1; if_req_addr = 32'h4;
        #1; chk("resume ready", 32'(if_req_ready), 1);
        tick(); idle();
        @(negedge clk); chk("resume data", if_rsp_data, 32'h2222_BBBB);
        tick();

        // Randomized traffic, requests held until accepted.
        acc_if = 1; acc_ld = 1;
        for (int c = 0; c < 3000; c++) begin
            if (acc_if) begin
                if_req_valid = ($urandom % 4) != 0;
                if_req_addr  = ($urandom & 32'hFFFF_F000) | (($urandom % 32) << 2) | ($urandom % 4);
            end
            if (acc_ld) begin
                ld_req_valid = ($urandom % 2) != 0;
                ld_req_we    = ($urandom % 2) != 0;
                ld_req_addr  = ($urandom & 32'hFFFF_F000) | (($urandom % 32) << 2) | ($urandom % 4);
                ld_req_wdata = $urandom;
            end
            rst_n = ($urandom % 150) != 0;
            @(negedge clk);
            acc_if = !if_req_valid || if_req_ready;
            acc_ld = !ld_req_valid || ld_req_ready;
            tick();
        end

        idle(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/itcm_arbiter.md
# itcm_arbiter

Shares the single-port instruction TCM (one-cycle registered read, write-first-cycle enable) between two requesters: the core's instruction-fetch stage (read-only) and the program loader/debug port (read/write). Fetch has fixed priority, with a starvation guard that forces a loader slot after a bounded number of losses. The block sits between the fetch unit, the loader and the TCM macro, and returns read data to the requester that issued each read.

## Interface
- DATA_WIDTH, 32, TCM word width
- ADDR_WIDTH, 10, TCM word-address width (depth 2^ADDR_WIDTH)
- MAX_STALL, 4, consecutive loader losses before a forced loader grant (>=1)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- if_req_valid  in  1  fetch read request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  32  fetch byte address
- if_rsp_valid  out  1  fetch read data valid (1-cycle pulse)
- if_rsp_data  out  DATA_WIDTH  fetch read data
- ld_req_valid  in  1  loader request
- ld_req_ready  out  1  loader request accepted this cycle
- ld_req_we  in  1  1 = write, 0 = read
- ld_req_addr  in  32  loader byte address
- ld_req_wdata  in  DATA_WIDTH  loader write data
- ld_rsp_valid  out  1  loader read data valid (1-cycle pulse; never for writes)
- ld_rsp_data  out  DATA_WIDTH  loader read data
- tcm_we  out  1  TCM write enable
- tcm_addr  out  ADDR_WIDTH  TCM word address
- tcm_wdata  out  DATA_WIDTH  TCM write data
- tcm_rdata  in  DATA_WIDTH  TCM registered read data (valid one cycle after access)

## Operation
- Word address = req_addr[ADDR_WIDTH+1:2]; bits [1:0] and bits above ADDR_WIDTH+1 ignored (aliasing).
- Grant is combinational per cycle; at most one request is accepted per cycle. The TCM port is driven combinationally from the granted request.
- Arbitration:
  - only one valid → that one granted
  - both valid, stall_cnt < MAX_STALL → fetch granted, stall_cnt increments
  - both valid, stall_cnt == MAX_STALL → loader granted (forced)
  - stall_cnt clears to 0 on any loader grant, or on any cycle ld_req_valid=0
- Nothing valid → tcm_we=0, tcm_addr=0, tcm_wdata=0, both ready=0.
- tcm_we = 1 only when loader granted with ld_req_we=1; tcm_wdata = ld_req_wdata then, else 0.
- Response tracking: 2-bit registered owner tag {none, fetch, loader-read} captured on each accepted read; the following cycle asserts the matching rsp_valid, and its rsp_data equals tcm_rdata. The other rsp_data is held at its previous value.
- Loader writes produce no response. A loader read of an address written the previous cycle returns the new data, because the TCM is written before it is read.
- Requesters must keep valid/addr/wdata stable until ready; the block does not buffer requests.

## Timing
- Reset (rst_n=0 at an edge): stall_cnt=0, owner tag=none, if_rsp_valid=0, ld_rsp_valid=0, if_rsp_data=0, ld_rsp_data=0. Combinational outputs follow the inputs; ready is forced to 0 and tcm_we to 0 while rst_n=0.
- Read latency: request accepted at edge N → rsp_valid high during cycle N+1 → data valid in that cycle. Back-to-back reads give one response per cycle.
- Write: takes effect at the accepting edge, zero response latency.
- Reset mid-operation: a response pending for the cycle after reset is dropped (rsp_valid stays 0).
- Worst-case loader wait under continuous fetch: MAX_STALL cycles lost, then a grant on the next cycle.

## Test plan
- Fetch only: if_req_valid held, addresses 0x0, 0x4, 0x8 with memory preloaded A/B/C → if_req_ready=1 every cycle; if_rsp_valid on each following cycle with data A, B, C.
- Loader write then read: write 0xDEADBEEF to 0x40, read 0x40 the next cycle → tcm_we pulses once with tcm_addr=0x10; ld_rsp_valid one cycle after the read with data 0xDEADBEEF; no ld_rsp_valid for the write.
- Contention with MAX_STALL=4: both valid continuously → fetch granted 4 cycles, loader granted on cycle 5, stall_cnt returns to 0, and the pattern repeats.
- Contention with the loader dropping valid after 2 losses, then reasserting → the counter restarts and 4 more fetch grants occur before the forced loader grant.
- Address aliasing: loader write to 0x1003 with ADDR_WIDTH=10 → tcm_addr=0x000; a fetch of 0x0 returns the written data.
- Reset asserted the cycle after an accepted fetch read → if_rsp_valid stays 0, all registered outputs are 0, and normal operation resumes on the first request after rst_n=1.
